game_over_ctl: RTL

//  Game-over controller. Tracks lives and owns the 'over' select that the VGA

---
 rtl/game_over_ctl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/game_over_ctl.sv
// Game-over controller: tracks lives, owns the frame-aligned 'over' select for the
// VGA stream mux, blinks the game-over text and issues game restart pulses.
module game_over_ctl #(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned HOLD_FRAMES  = 180,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vblnk_i,
    input  logic                       catch_i,
    input  logic                       restart_i,
    output logic                       over_o,
    output logic                       text_en_o,
    output logic [$clog2(LIVES+1)-1:0] lives_o,
    output logic                       game_rst_o
);

    localparam int unsigned LW = $clog2(LIVES + 1);
    localparam int unsigned FW = (HOLD_FRAMES  > 1) ? $clog2(HOLD_FRAMES)  : 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [2:0] {
        S_PLAY,
        S_DIE_WAIT,
        S_OVER,
        S_READY,
        S_RESTART
    } state_t;

    state_t          state_q;
    logic            vblnk_q;
    logic            over_q;
    logic            text_en_q;
    logic [LW-1:0]   lives_q;
    logic            game_rst_q;
    logic [FW-1:0]   frame_cnt_q;
    logic [BW-1:0]   blink_cnt_q;
    logic            tick;

    // Frame tick on the first cycle of vblank; every 'over' change is gated by it.
    assign tick = vblnk_i & ~vblnk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PLAY;
            vblnk_q     <= 1'b0;
            over_q      <= 1'b0;
            text_en_q   <= 1'b0;
            lives_q     <= LW'(LIVES);
            game_rst_q  <= 1'b0;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
        end else begin
            vblnk_q    <= vblnk_i;
            game_rst_q <= 1'b0;
            case (state_q)
                S_PLAY: begin
                    if (catch_i) begin
                        if (lives_q > LW'(1)) begin
                            lives_q    <= lives_q - LW'(1);
                            // Back-to-back catches must not stretch the respawn pulse.
                            game_rst_q <= ~game_rst_q;
                        end else begin
                            lives_q <= '0;
                            state_q <= S_DIE_WAIT;
                        end
                    end
                end
                S_DIE_WAIT: begin
                    if (tick) begin
                        over_q      <= 1'b1;
                        text_en_q   <= 1'b1;
                        frame_cnt_q <= FW'(HOLD_FRAMES - 1);
                        blink_cnt_q <= BW'(BLINK_FRAMES - 1);
                        state_q     <= S_OVER;
                    end
                end
                S_OVER: begin
                    if (tick) begin
                        if (blink_cnt_q == '0) begin
                            text_en_q   <= ~text_en_q;
                            blink_cnt_q <= BW'(BLINK_FRAMES - 1);
                        end else begin
                            blink_cnt_q <= blink_cnt_q - BW'(1);
                        end
                        // End of hold wins over the blink toggle: text stays on in READY.
                        if (frame_cnt_q == '0) begin
                            text_en_q <= 1'b1;
                            state_q   <= S_READY;
                        end else begin
                            frame_cnt_q <= frame_cnt_q - FW'(1);
                        end
                    end
                end
                S_READY: begin
                    if (restart_i) begin
                        state_q <= S_RESTART;
                    end
                end
                S_RESTART: begin
                    if (tick) begin
                        over_q     <= 1'b0;
                        text_en_q  <= 1'b0;
                        lives_q    <= LW'(LIVES);
                        game_rst_q <= 1'b1;
                        state_q    <= S_PLAY;
                    end
                end
                default: state_q <= S_PLAY;
            endcase
        end
    end

    assign over_o     = over_q;
    assign text_en_o  = text_en_q;
    assign lives_o    = lives_q;
    assign game_rst_o = game_rst_q;

endmodule
